// File: rtl/lsu_ctrl_if.sv
// Data-memory bus between lsu_ctrl (master) and the memory port (slave):
// word-addressed request/acknowledge with byte strobes.
interface lsu_ctrl_if #(
    parameter int DMEM_AW = 32
);
    logic               o_dmem_req;
    logic               o_dmem_we;
    logic [DMEM_AW-1:0] o_dmem_addr;
    logic [3:0]         o_dmem_wstrb;
    logic [31:0]        o_dmem_wdata;
    logic               i_dmem_ack;
    logic [31:0]        i_dmem_rdata;

    modport master (
        output o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wstrb, o_dmem_wdata,
        input  i_dmem_ack, i_dmem_rdata
    );

    modport slave (
        input  o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_wstrb, o_dmem_wdata,
        output i_dmem_ack, i_dmem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one memory op per request, lane-shifted stores, extended loads.
// Optional macro LSU_MISALIGN_SPLIT_EN splits word-crossing accesses into two bus transactions.
module lsu_ctrl #(
    parameter int DMEM_AW = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [3:0]         i_mem_op,
    input  logic [DMEM_AW-1:0] i_addr,
    input  logic [31:0]        i_wdata,
    output logic               o_done,
    output logic               o_fault,
    output logic [31:0]        o_rdata,
    lsu_ctrl_if.master         dmem
);

    localparam logic [3:0] MEM_LB   = 4'd0;
    localparam logic [3:0] MEM_LH   = 4'd1;
    localparam logic [3:0] MEM_LW   = 4'd2;
    localparam logic [3:0] MEM_LB_U = 4'd3;
    localparam logic [3:0] MEM_LH_U = 4'd4;
    localparam logic [3:0] MEM_SB   = 4'd5;
    localparam logic [3:0] MEM_SH   = 4'd6;
    localparam logic [3:0] MEM_SW   = 4'd7;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam logic [1:0] ACC1 = 2'd2;
`endif
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0] state;
    logic [3:0] op_q;
    logic [1:0] off_q;

    // Decode of the incoming request, used only on the accepting edge.
    logic [1:0]  in_off;
    logic [2:0]  in_size;
    logic [3:0]  in_mask;
    logic        in_illegal;
    logic        in_store;
    logic        in_fault;
    logic [3:0]  strb_lo;
    logic [31:0] wdata_lo;

    assign in_off = i_addr[1:0];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        in_size    = 3'd1;
        in_mask    = 4'b0001;
        in_illegal = 1'b0;
        case (i_mem_op)
            MEM_LB, MEM_LB_U, MEM_SB: begin
                in_size = 3'd1;
                in_mask = 4'b0001;
            end
            MEM_LH, MEM_LH_U, MEM_SH: begin
                in_size = 3'd2;
                in_mask = 4'b0011;
            end
            MEM_LW, MEM_SW: begin
                in_size = 3'd4;
                in_mask = 4'b1111;
            end
            default: in_illegal = 1'b1;
        endcase
    end

    assign in_store = (i_mem_op == MEM_SB) || (i_mem_op == MEM_SH) || (i_mem_op == MEM_SW);

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        in_cross;
    logic [7:0]  strb_wide;
    logic [63:0] wdata_wide;
    logic        split_q;
    logic [31:0] lo_q;
    logic [3:0]  strb_hi_q;
    logic [31:0] wdata_hi_q;
    logic [63:0] merged;

    assign in_cross   = ({1'b0, in_off} + in_size) > 3'd4;
    assign in_fault   = in_illegal;
    // The upper half of the widened shift is exactly what the second word needs.
    assign strb_wide  = {4'b0000, in_mask} << in_off;
    assign wdata_wide = {32'd0, i_wdata} << {in_off, 3'b000};
    assign strb_lo    = strb_wide[3:0];
    assign wdata_lo   = wdata_wide[31:0];

    assign merged = split_q ? {dmem.i_dmem_rdata, lo_q} : {32'd0, dmem.i_dmem_rdata};

    logic [31:0] load_raw;
    assign load_raw = 32'(merged >> {off_q, 3'b000});
`else
    logic in_misal;

    assign in_misal = ((in_size == 3'd2) && in_off[0]) || ((in_size == 3'd4) && (in_off != 2'd0));
    assign in_fault = in_illegal || in_misal;
    assign strb_lo  = in_mask << in_off;
    assign wdata_lo = i_wdata << {in_off, 3'b000};

    logic [31:0] load_raw;
    assign load_raw = dmem.i_dmem_rdata >> {off_q, 3'b000};
`endif

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [3:0] op);
        case (op)
            MEM_LB:   extend = {{24{raw[7]}}, raw[7:0]};
            MEM_LB_U: extend = {24'd0, raw[7:0]};
            MEM_LH:   extend = {{16{raw[15]}}, raw[15:0]};
            MEM_LH_U: extend = {16'd0, raw[15:0]};
            default:  extend = raw;
        endcase
    endfunction

    logic [31:0] load_ext;
    assign load_ext = extend(load_raw, op_q);

    assign o_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            op_q              <= 4'd0;
            off_q             <= 2'd0;
            o_done            <= 1'b0;
            o_fault           <= 1'b0;
            o_rdata           <= 32'd0;
            dmem.o_dmem_req   <= 1'b0;
            dmem.o_dmem_we    <= 1'b0;
            dmem.o_dmem_addr  <= '0;
            dmem.o_dmem_wstrb <= 4'd0;
            dmem.o_dmem_wdata <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
            split_q           <= 1'b0;
            lo_q              <= 32'd0;
            strb_hi_q         <= 4'd0;
            wdata_hi_q        <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        op_q  <= i_mem_op;
                        off_q <= in_off;
                        if (in_fault) begin
                            state   <= RESP;
                            o_done  <= 1'b1;
                            o_fault <= 1'b1;
                            o_rdata <= 32'd0;
                        end else begin
                            state             <= ACC0;
                            dmem.o_dmem_req   <= 1'b1;
                            dmem.o_dmem_we    <= in_store;
                            dmem.o_dmem_addr  <= {i_addr[DMEM_AW-1:2], 2'b00};
                            dmem.o_dmem_wstrb <= in_store ? strb_lo : 4'd0;
                            dmem.o_dmem_wdata <= in_store ? wdata_lo : 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                            split_q           <= in_cross;
                            strb_hi_q         <= in_store ? strb_wide[7:4] : 4'd0;
                            wdata_hi_q        <= in_store ? wdata_wide[63:32] : 32'd0;
`endif
                        end
                    end
                end

                ACC0: begin
                    if (dmem.i_dmem_ack) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                        if (split_q) begin
                            // Request stays high; only address and lanes move to the next word.
                            state             <= ACC1;
                            lo_q              <= dmem.i_dmem_rdata;
                            dmem.o_dmem_addr  <= dmem.o_dmem_addr + DMEM_AW'(4);
                            dmem.o_dmem_wstrb <= strb_hi_q;
                            dmem.o_dmem_wdata <= wdata_hi_q;
                        end else begin
                            state             <= RESP;
                            o_done            <= 1'b1;
                            o_rdata           <= dmem.o_dmem_we ? 32'd0 : load_ext;
                            dmem.o_dmem_req   <= 1'b0;
                            dmem.o_dmem_we    <= 1'b0;
                            dmem.o_dmem_wstrb <= 4'd0;
                        end
`else
                        state             <= RESP;
                        o_done            <= 1'b1;
                        o_rdata           <= dmem.o_dmem_we ? 32'd0 : load_ext;
                        dmem.o_dmem_req   <= 1'b0;
                        dmem.o_dmem_we    <= 1'b0;
                        dmem.o_dmem_wstrb <= 4'd0;
`endif
                    end
                end

`ifdef LSU_MISALIGN_SPLIT_EN
                ACC1: begin
                    if (dmem.i_dmem_ack) begin
                        state             <= RESP;
                        o_done            <= 1'b1;
                        o_rdata           <= dmem.o_dmem_we ? 32'd0 : load_ext;
                        dmem.o_dmem_req   <= 1'b0;
                        dmem.o_dmem_we    <= 1'b0;
                        dmem.o_dmem_wstrb <= 4'd0;
                    end
                end
`endif

                RESP: begin
                    state   <= IDLE;
                    o_done  <= 1'b0;
                    o_fault <= 1'b0;
                    o_rdata <= 32'd0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl; follows LSU_MISALIGN_SPLIT_EN when defined.
module tb_lsu_ctrl;

    localparam int DMEM_AW = 32;

    localparam logic [3:0] LB   = 4'd0;
    localparam logic [3:0] LH   = 4'd1;
    localparam logic [3:0] LW   = 4'd2;
    localparam logic [3:0] LB_U = 4'd3;
    localparam logic [3:0] LH_U = 4'd4;
    localparam logic [3:0] SB   = 4'd5;
    localparam logic [3:0] SH   = 4'd6;
    localparam logic [3:0] SW   = 4'd7;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               i_valid = 1'b0;
    logic               o_ready;
    logic [3:0]         i_mem_op = 4'd0;
    logic [DMEM_AW-1:0] i_addr = '0;
    logic [31:0]        i_wdata = 32'd0;
    logic               o_done;
    logic               o_fault;
    logic [31:0]        o_rdata;

    int checks = 0;
    int errors = 0;

    lsu_ctrl_if #(.DMEM_AW(DMEM_AW)) dmem ();

    lsu_ctrl #(.DMEM_AW(DMEM_AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mem_op (i_mem_op),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .o_done   (o_done),
        .o_fault  (o_fault),
        .o_rdata  (o_rdata),
        .dmem     (dmem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns at T+1.
    task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_valid  = 1'b1;
        i_mem_op = op;
        i_addr   = addr;
        i_wdata  = wdata;
        step();
        i_valid  = 1'b0;
    endtask

    initial begin
        dmem.i_dmem_ack   = 1'b0;
        dmem.i_dmem_rdata = 32'd0;

        // Reset state
        step();
        step();
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_done",  32'(o_done),  32'd0);
        check("rst_fault", 32'(o_fault), 32'd0);
        check("rst_req",   32'(dmem.o_dmem_req), 32'd0);
        check("rst_we",    32'(dmem.o_dmem_we),  32'd0);
        check("rst_wstrb", 32'(dmem.o_dmem_wstrb), 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_addr",  dmem.o_dmem_addr, 32'd0);
        check("rst_wdata", dmem.o_dmem_wdata, 32'd0);
        rst = 1'b0;
        step();

        // Stray ack while idle is ignored
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'hFFFF_FFFF;
        step();
        check("idle_ack_req",  32'(dmem.o_dmem_req), 32'd0);
        check("idle_ack_done", 32'(o_done), 32'd0);
        dmem.i_dmem_ack   = 1'b0;

        // SW 0x100, zero-wait ack
        issue("sw", SW, 32'h0000_0100, 32'hDEAD_BEEF);
        check("sw_req",   32'(dmem.o_dmem_req), 32'd1);
        check("sw_we",    32'(dmem.o_dmem_we),  32'd1);
        check("sw_addr",  dmem.o_dmem_addr, 32'h0000_0100);
        check("sw_wstrb", 32'(dmem.o_dmem_wstrb), 32'hF);
        check("sw_wdata", dmem.o_dmem_wdata, 32'hDEAD_BEEF);
        check("sw_done_t1", 32'(o_done), 32'd0);
        dmem.i_dmem_ack = 1'b1;
        step();
        dmem.i_dmem_ack = 1'b0;
        check("sw_done",  32'(o_done),  32'd1);
        check("sw_fault", 32'(o_fault), 32'd0);
        check("sw_rdata", o_rdata, 32'd0);
        check("sw_req_drop", 32'(dmem.o_dmem_req), 32'd0);
        check("sw_ready_resp", 32'(o_ready), 32'd0);
        step();
        check("sw_done_clr", 32'(o_done), 32'd0);

        // LB 0x203 back-to-back at done+1, ack after three wait cycles
        issue("lb", LB, 32'h0000_0203, 32'd0);
        check("lb_req",   32'(dmem.o_dmem_req), 32'd1);
        check("lb_we",    32'(dmem.o_dmem_we),  32'd0);
        check("lb_addr",  dmem.o_dmem_addr, 32'h0000_0200);
        check("lb_wstrb", 32'(dmem.o_dmem_wstrb), 32'd0);
        step();
        step();
        step();
        check("lb_req_held", 32'(dmem.o_dmem_req), 32'd1);
        check("lb_addr_held", dmem.o_dmem_addr, 32'h0000_0200);
        check("lb_done_wait", 32'(o_done), 32'd0);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h80FF_FFFF;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lb_done",  32'(o_done), 32'd1);
        check("lb_rdata", o_rdata, 32'hFFFF_FF80);
        step();

        // LHU 0x202
        issue("lhu", LH_U, 32'h0000_0202, 32'd0);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h8001_AAAA;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lhu_done",  32'(o_done), 32'd1);
        check("lhu_rdata", o_rdata, 32'h0000_8001);
        step();

        // LH 0x202, same word, sign-extended
        issue("lh", LH, 32'h0000_0202, 32'd0);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h8001_AAAA;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lh_rdata", o_rdata, 32'hFFFF_8001);
        step();

        // LBU 0x201
        issue("lbu", LB_U, 32'h0000_0201, 32'd0);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h1234_9A78;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lbu_rdata", o_rdata, 32'h0000_009A);
        step();

        // SB 0x101
        issue("sb", SB, 32'h0000_0101, 32'h0000_005A);
        check("sb_addr",  dmem.o_dmem_addr, 32'h0000_0100);
        check("sb_wstrb", 32'(dmem.o_dmem_wstrb), 32'h2);
        check("sb_wdata", dmem.o_dmem_wdata, 32'h0000_5A00);
        dmem.i_dmem_ack = 1'b1;
        step();
        dmem.i_dmem_ack = 1'b0;
        check("sb_done", 32'(o_done), 32'd1);
        step();

        // SH 0x102
        issue("sh", SH, 32'h0000_0102, 32'hFFFF_1234);
        check("sh_wstrb", 32'(dmem.o_dmem_wstrb), 32'hC);
        check("sh_wdata", dmem.o_dmem_wdata, 32'h1234_0000);
        dmem.i_dmem_ack = 1'b1;
        step();
        dmem.i_dmem_ack = 1'b0;
        check("sh_done", 32'(o_done), 32'd1);
        step();

`ifdef LSU_MISALIGN_SPLIT_EN
        // LW 0x103 crosses a word: two accesses
        issue("lw_x", LW, 32'h0000_0103, 32'd0);
        check("lw_x_addr0", dmem.o_dmem_addr, 32'h0000_0100);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h1122_3344;
        step();
        check("lw_x_req1",  32'(dmem.o_dmem_req), 32'd1);
        check("lw_x_addr1", dmem.o_dmem_addr, 32'h0000_0104);
        check("lw_x_done_t2", 32'(o_done), 32'd0);
        dmem.i_dmem_rdata = 32'h5566_7788;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lw_x_done",  32'(o_done), 32'd1);
        check("lw_x_fault", 32'(o_fault), 32'd0);
        check("lw_x_rdata", o_rdata, 32'h6677_8811);
        step();

        // SH 0xFFFFFFFF wraps to word 0
        issue("sh_wrap", SH, 32'hFFFF_FFFF, 32'h0000_ABCD);
        check("sh_wrap_addr0",  dmem.o_dmem_addr, 32'hFFFF_FFFC);
        check("sh_wrap_wstrb0", 32'(dmem.o_dmem_wstrb), 32'h8);
        check("sh_wrap_wdata0", dmem.o_dmem_wdata, 32'hCD00_0000);
        dmem.i_dmem_ack = 1'b1;
        step();
        check("sh_wrap_addr1",  dmem.o_dmem_addr, 32'h0000_0000);
        check("sh_wrap_wstrb1", 32'(dmem.o_dmem_wstrb), 32'h1);
        check("sh_wrap_wdata1", dmem.o_dmem_wdata, 32'h0000_00AB);
        step();
        dmem.i_dmem_ack = 1'b0;
        check("sh_wrap_done",  32'(o_done), 32'd1);
        check("sh_wrap_fault", 32'(o_fault), 32'd0);
        step();

        // LH 0x201 is misaligned but stays within one word
        issue("lh_mis", LH, 32'h0000_0201, 32'd0);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h11F0_8899;
        step();
        dmem.i_dmem_ack   = 1'b0;
        check("lh_mis_done",  32'(o_done), 32'd1);
        check("lh_mis_rdata", o_rdata, 32'hFFFF_F088);
        step();
`else
        // Misaligned W and H fault at T+1 with no bus request
        issue("lw_x", LW, 32'h0000_0103, 32'd0);
        check("lw_x_done",  32'(o_done), 32'd1);
        check("lw_x_fault", 32'(o_fault), 32'd1);
        check("lw_x_req",   32'(dmem.o_dmem_req), 32'd0);
        step();

        issue("lh_mis", LH, 32'h0000_0201, 32'd0);
        check("lh_mis_fault", 32'(o_fault), 32'd1);
        check("lh_mis_req",   32'(dmem.o_dmem_req), 32'd0);
        check("lh_mis_rdata", o_rdata, 32'd0);
        step();
`endif

        // Illegal op code
        issue("ill", 4'd9, 32'h0000_0100, 32'd0);
        check("ill_done",  32'(o_done), 32'd1);
        check("ill_fault", 32'(o_fault), 32'd1);
        check("ill_req",   32'(dmem.o_dmem_req), 32'd0);
        check("ill_rdata", o_rdata, 32'd0);
        step();
        check("ill_done_clr",  32'(o_done), 32'd0);
        check("ill_fault_clr", 32'(o_fault), 32'd0);

        // Reset in ACC0 with ack asserted
        issue("rst_mid", LW, 32'h0000_0300, 32'd0);
        check("rst_mid_req", 32'(dmem.o_dmem_req), 32'd1);
        dmem.i_dmem_ack   = 1'b1;
        dmem.i_dmem_rdata = 32'h1234_5678;
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem.i_dmem_ack = 1'b0;
        check("rst_mid_req0",  32'(dmem.o_dmem_req), 32'd0);
        check("rst_mid_done",  32'(o_done), 32'd0);
        check("rst_mid_ready", 32'(o_ready), 32'd1);
        step();
        check("rst_mid_done2", 32'(o_done), 32'd0);
        check("rst_mid_rdata", o_rdata, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer between the execute stage and the data-memory port. Accepts one memory operation (encoded with the `MEM_*` mask-select codes), drives a word-addressed req/ack bus with byte strobes, lane-shifts store data, and merges, aligns and sign/zero-extends load data. It completes each operation with a single-cycle `o_done` pulse. An optional mode splits word-crossing misaligned accesses into two bus transactions.

## Interface
- `DMEM_AW`, 32: byte-address width; bus address is word-aligned (`[1:0]` = 0).
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  operation request; sampled only when `o_ready`=1.
- `o_ready`  out  1  high when idle (state IDLE).
- `i_mem_op`  in  4  `MEM_LB`=0, `LH`=1, `LW`=2, `LB_U`=3, `LH_U`=4, `SB`=5, `SH`=6, `SW`=7; codes 8–15 are illegal.
- `i_addr`  in  `DMEM_AW`  byte address.
- `i_wdata`  in  32  store data, right-justified.
- `o_done`  out  1  one-cycle completion pulse.
- `o_fault`  out  1  qualifies `o_done`; set for an illegal op or an unsupported misalignment.
- `o_rdata`  out  32  extended load result; valid with `o_done`; 0 for stores and faults.
- `o_dmem_req`  out  1  bus request; held until acked.
- `o_dmem_we`  out  1  1 = write.
- `o_dmem_addr`  out  `DMEM_AW`  word address.
- `o_dmem_wstrb`  out  4  byte-lane enables; 0 for reads.
- `o_dmem_wdata`  out  32  lane-shifted store data.
- `i_dmem_ack`  in  1  completes the current request; may arrive in the same cycle as the request is raised.
- `i_dmem_rdata`  in  32  read word; valid with ack.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- IDLE:
  - On `i_valid`, register op, address and data.
  - If the op is illegal or the access is misaligned-and-unsupported, go to RESP with fault. Otherwise go to ACC0.
- ACC0: drive the access for word `addr & ~3`.
  - On ack: go to ACC1 if the access is split, else go to RESP.
- ACC1: drive the access for word `(addr & ~3) + 4`, 32-bit wrap (`0xFFFFFFFC` → `0x00000000`). On ack go to RESP.
- RESP: pulse `o_done` (plus `o_fault` if flagged), present `o_rdata`, then go to IDLE.
- Misalignment definition:
  - H ops: misaligned when `addr[0]`=1.
  - W ops: misaligned when `addr[1:0]`≠0.
  - B ops: never misaligned.
- Offset and size: `off = addr[1:0]`; size `n` = 1, 2 or 4. An access crosses a word when `off + n > 4`.
- Store lanes:
  - ACC0: `wdata << 8*off`; strobe `((1<<n)-1) << off`, truncated to 4 bits.
  - ACC1: `wdata >> 8*(4-off)`; strobe = remaining low lanes.
- Load merge:
  - ACC0 bytes `[off..3]` form the low bytes; ACC1 bytes fill the upper bytes.
  - The result is shifted down by `off`, masked to `n` bytes, then extended: sign-extend for LB/LH, zero-extend for LB_U/LH_U. LW is unchanged.
- Acks seen in IDLE or RESP are ignored.

## Timing
- Reset values:
  - state = IDLE, `o_ready`=1.
  - `o_done`, `o_fault`, `o_dmem_req`, `o_dmem_we` = 0.
  - `o_dmem_wstrb`=0, `o_rdata`=0, `o_dmem_addr`=0, `o_dmem_wdata`=0.
- Latency, with acceptance at cycle T:
  - `o_dmem_req` rises at T+1.
  - Zero-wait ack → `o_done` at T+2.
  - Split access with zero-wait acks → `o_done` at T+3.
  - Fault → `o_done`/`o_fault` at T+1, with no bus activity.
- Each wait cycle adds one cycle of latency.
- Bus request rules:
  - `o_dmem_req` and all bus outputs are registered and held stable until the ack cycle.
  - `o_dmem_req` drops in the cycle after the ack unless ACC1 follows. ACC0→ACC1 keeps req high with new address/strobe.
- Back-to-back throughput: the next acceptance is possible at the `o_done`+1 cycle, so the minimum period is 3 cycles.
- `rst` mid-operation: the next edge returns to IDLE and clears outputs. An in-flight ack is dropped and no `o_done` is produced.

## Configuration
- `LSU_MISALIGN_SPLIT_EN` defined:
  - Misaligned accesses within one word complete in a single access.
  - Word-crossing accesses use ACC0+ACC1.
  - `o_fault` occurs only for illegal ops.
- Not defined:
  - Every misaligned H/W access faults at T+1 with no bus request.
  - The ACC1 state and merge logic are removed.

## Test plan
- SW addr `0x100`, data `0xDEADBEEF`, ack zero-wait → req at T+1, addr `0x100`, wstrb `1111`, wdata `0xDEADBEEF`, `o_done` at T+2, `o_fault`=0.
- LB addr `0x203`, rdata `0x80FFFFFF`, ack delayed 3 cycles → addr `0x200`, wstrb `0000`, `o_rdata`=`0xFFFFFF80`, `o_done` at T+5.
- LHU addr `0x202`, rdata `0x8001AAAA` → `o_rdata`=`0x00008001`.
- LW addr `0x103`:
  - With macro: accesses `0x100` (rdata `0x11223344`) then `0x104` (rdata `0x55667788`) → `o_rdata`=`0x66778811`, `o_done` at T+3.
  - Without macro: `o_done`+`o_fault` at T+1, no req.
- SH addr `0xFFFFFFFF`, data `0xABCD`, with macro → ACC0 addr `0xFFFFFFFC`, wstrb `1000`, wdata `0xCD000000`; ACC1 addr `0x0`, wstrb `0001`, wdata byte0 `0xAB`.
- `i_mem_op`=9 → fault at T+1. Separately, `rst` in ACC0 with ack asserted → IDLE next cycle, req=0, no `o_done`.
